mac_accumulator: RTL and testbench
==================================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter ACC_W, default 24, accumulator and result width in bits.
REQ-002 Parameter LEN_W, default 8, width of the dot-product length field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a new accumulation; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of products to sum; latched when start is accepted.
REQ-007 in_valid  input  1  product input carries valid data (driven by the 8x8 multiplier stage).
REQ-008 in_ready  output  1  block accepts a product this cycle.
REQ-009 product  input  16  unsigned 16-bit product.
REQ-010 out_valid  output  1  acc_out holds a completed sum.
REQ-011 out_ready  input  1  consumer takes acc_out this cycle.
REQ-012 acc_out  output  ACC_W  unsigned accumulated sum.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-015 IDLE: in_ready=0, out_valid=0; when start=1, the block SHALL latch len into the remaining-count register, clear the accumulator to 0 and move to ACCUM if len!=0, or to DONE if len==0.
REQ-016 ACCUM: in_ready=1; a beat is in_valid&in_ready; each beat SHALL add zero-extended product to the accumulator and decrement the remaining count.
REQ-017 When a beat consumes the final product (remaining count == 1), the next state SHALL be DONE, with the final sum visible on acc_out in that same next cycle (one-cycle latency from the last beat to out_valid).
REQ-018 Cycles in ACCUM with in_valid=0 SHALL leave the accumulator and count unchanged (stall, no timeout).
REQ-019 DONE: out_valid=1, in_ready=0; acc_out and out_valid SHALL hold stable until out_ready=1, then the FSM SHALL return to IDLE in the next cycle.
REQ-020 start asserted in ACCUM or DONE SHALL be ignored and not queued.
REQ-021 Arithmetic SHALL be unsigned, with no saturation or wrap-around for the defaults: 255 x 65025 = 16,581,375 < 2^24. For the defaults, len SHALL range over 0..255.
REQ-022 acc_out SHALL present the running accumulator value in every state; consumers qualify it with out_valid only.
REQ-023 in_ready SHALL depend only on the state register, with no combinational path from in_valid, start or out_ready.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, accumulator=0, count=0, in_ready=0, out_valid=0, busy=0, acc_out=0, regardless of clk.
REQ-025 Reset during ACCUM or DONE SHALL discard the partial or unread sum; the first cycle after release SHALL be IDLE.

Structure
REQ-026 Shared package mac_pkg SHALL hold the state enum (IDLE, ACCUM, DONE) and the ACC_W/LEN_W default constants.
REQ-027 Accumulation SHALL use one sub-module, adder_24bit (ripple adder with a carry-in tied to 0, carry-out unused), instantiated once.
REQ-028 All registers SHALL be in one clocked process with asynchronous active-low reset; next-state logic SHALL be combinational.

Verification
REQ-029 start with len=3, products 100, 200, 300 on consecutive cycles, out_ready=1 -> out_valid one cycle after the third beat, acc_out=600, then IDLE.
REQ-030 start with len=0 -> DONE on the next cycle, acc_out=0, out_valid=1; no beats accepted.
REQ-031 len=255 with all products 65025 -> acc_out=16,581,375.
REQ-032 len=2, products 7 and 9 separated by 4 in_valid=0 cycles; out_ready held low 5 cycles -> acc_out=16 stable and out_valid high throughout; IDLE one cycle after out_ready rises.
REQ-033 start pulsed during ACCUM (len=2, sum in progress) -> no restart and result unchanged; rst_n pulsed low mid-ACCUM -> all outputs 0 immediately, then a fresh len=1 with product 5 yields 5.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default sizes for the MAC accumulator slice.
// Holds the FSM state encoding and width defaults.
package mac_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 8;
  localparam int PROD_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/adder_24bit.sv
// Ripple-carry adder used for the running sum.
// Carry is chained bit by bit through a block-local variable.
module adder_24bit #(
  parameter int W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o
);

  // Bitwise full-adder chain from LSB to MSB
  always_comb begin : ripple
    logic c;
    c   = ci_i;
    s_o = '0;
    for (int i = 0; i < W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end

endmodule

// File: rtl/mac_accumulator.sv
// Length-framed accumulator of unsigned 16-bit products.
// IDLE -> ACCUM (len beats) -> DONE (hold until taken).
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, vld_q, busy_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             unused_co;

  assign prod_ext = ACC_W'(product);

  adder_24bit #(
    .W (ACC_W)
  ) u_add (
    .a_i  (acc_q),
    .b_i  (prod_ext),
    .ci_i (1'b0),
    .s_o  (sum),
    .co_o (unused_co)
  );

  // Next state, sum and remaining count
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = len;
          acc_d   = '0;
          state_d = (len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state plus registered handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == ACCUM);
      vld_q   <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mac_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] product;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] acc_out;
  logic        busy;

  int total;
  int bad;

  mac_accumulator #(
    .ACC_W (24),
    .LEN_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    product   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    chk("rst_acc", acc_out, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // len=3: 100+200+300
    @(negedge clk);
    start = 1'b1; len = 8'd3; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_rdy", in_ready, 1);
    chk("t1_busy", busy, 1);
    chk("t1_clr", acc_out, 0);
    in_valid = 1'b1; product = 16'd100;
    @(negedge clk);
    product = 16'd200;
    @(negedge clk);
    product = 16'd300;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_vld", out_valid, 1);
    chk("t1_sum", acc_out, 600);
    chk("t1_rdy0", in_ready, 0);
    @(negedge clk);
    chk("t1_idle", busy, 0);
    chk("t1_vld0", out_valid, 0);
    out_ready = 1'b0;

    // len=0: straight to DONE, no beat taken
    @(negedge clk);
    start = 1'b1; len = 8'd0;
    in_valid = 1'b1; product = 16'd55;
    @(negedge clk);
    start = 1'b0;
    chk("t2_vld", out_valid, 1);
    chk("t2_sum", acc_out, 0);
    chk("t2_rdy", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_idle", busy, 0);
    chk("t2_sum2", acc_out, 0);
    in_valid = 1'b0; out_ready = 1'b0;

    // len=255, all products 65025
    @(negedge clk);
    start = 1'b1; len = 8'd255;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; product = 16'd65025;
    repeat (254) @(negedge clk);
    chk("t3_part_vld", out_valid, 0);
    chk("t3_part", acc_out, 16516350);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_vld", out_valid, 1);
    chk("t3_sum", acc_out, 16581375);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_idle", busy, 0);
    out_ready = 1'b0;

    // len=2 with stalls and back-pressure
    @(negedge clk);
    start = 1'b1; len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; product = 16'd7;
    @(negedge clk);
    in_valid = 1'b0; product = 16'd0;
    repeat (4) @(negedge clk);
    chk("t4_stall", acc_out, 7);
    chk("t4_srdy", in_ready, 1);
    chk("t4_svld", out_valid, 0);
    in_valid = 1'b1; product = 16'd9;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_vld", out_valid, 1);
    chk("t4_sum", acc_out, 16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_vld", out_valid, 1);
      chk("t4_hold_sum", acc_out, 16);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_idle", busy, 0);
    chk("t4_vld0", out_valid, 0);
    out_ready = 1'b0;

    // start ignored in ACCUM and in DONE
    @(negedge clk);
    start = 1'b1; len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; product = 16'd10;
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1; len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    chk("t5_norst", acc_out, 10);
    chk("t5_rdy", in_ready, 1);
    in_valid = 1'b1; product = 16'd20;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_vld", out_valid, 1);
    chk("t5_sum", acc_out, 30);
    start = 1'b1; len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t5_dvld", out_valid, 1);
    chk("t5_dsum", acc_out, 30);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t5_idle", busy, 0);
    @(negedge clk);
    chk("t5_noq", busy, 0);

    // async reset mid-ACCUM, then a fresh run
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; product = 16'd50;
    @(negedge clk);
    chk("t6_part", acc_out, 50);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_acc0", acc_out, 0);
    chk("t6_busy0", busy, 0);
    chk("t6_rdy0", in_ready, 0);
    chk("t6_vld0", out_valid, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle", busy, 0);
    start = 1'b1; len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; product = 16'd5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_vld", out_valid, 1);
    chk("t6_sum", acc_out, 5);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_end", busy, 0);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
